// File: rtl/sqrt2_bus_ctrl.sv
// sqrt2_bus_ctrl: puts one FP16 operand on the sqrt2 bus for a single ENABLE cycle, then captures the result or flags; OUT_VALID rises 1+n cycles after accept and holds until OUT_READY.
// Build option SQRT2_BUS_CTRL_BYPASS_EN answers +/-0, +/-inf and NaN operands locally, one cycle after accept, without engaging sqrt2.
module sqrt2_bus_ctrl #(
  parameter int TIMEOUT_CYC = 64,
  parameter int GAP_CYC     = 1
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic [15:0] IN_DATA,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [15:0] OUT_DATA,
  output logic        OUT_NAN,
  output logic        OUT_PINF,
  output logic        OUT_NINF,
  output logic        OUT_TIMEOUT,
  output logic        BUSY,
  inout  wire  [15:0] SQ_IO_DATA,
  output logic        SQ_ENABLE,
  input  logic        SQ_IS_NAN,
  input  logic        SQ_IS_PINF,
  input  logic        SQ_IS_NINF,
  input  logic        SQ_RESULT
);
  localparam int WCW = $clog2(TIMEOUT_CYC + 1);
  localparam int GCW = $clog2(GAP_CYC + 1);
  localparam logic [15:0] QNAN = 16'h7E00;
  localparam logic [15:0] PINF = 16'h7C00;

  typedef enum logic [2:0] {S_IDLE, S_DRIVE, S_WAIT, S_HOLD, S_GAP} state_t;

  state_t         state_q, state_d;
  logic [15:0]    op_q, op_d;
  logic [WCW-1:0] wcnt_q, wcnt_d;
  logic [GCW-1:0] gcnt_q, gcnt_d;
  logic [15:0]    res_q, res_d;
  logic           nan_q, nan_d, pinf_q, pinf_d, ninf_q, ninf_d, to_q, to_d;
  logic           accept, done;

  assign accept = IN_VALID && IN_READY;
  assign done   = SQ_RESULT | SQ_IS_NAN | SQ_IS_PINF | SQ_IS_NINF;

  // Reset gates IN_READY directly because the state register alone reads IDLE during reset.
  assign IN_READY    = RST_N && (state_q == S_IDLE);
  assign SQ_ENABLE   = (state_q == S_DRIVE) || (state_q == S_WAIT);
  assign SQ_IO_DATA  = (state_q == S_DRIVE) ? op_q : 16'hzzzz;
  assign OUT_VALID   = (state_q == S_HOLD);
  assign BUSY        = (state_q != S_IDLE);
  assign OUT_DATA    = res_q;
  assign OUT_NAN     = nan_q;
  assign OUT_PINF    = pinf_q;
  assign OUT_NINF    = ninf_q;
  assign OUT_TIMEOUT = to_q;

`ifdef SQRT2_BUS_CTRL_BYPASS_EN
  logic        byp_hit, byp_nan, byp_pinf, byp_ninf, bypass_q, bypass_d;
  logic [15:0] byp_dat;

  always_comb begin
    byp_hit  = 1'b0;
    byp_dat  = IN_DATA;
    byp_nan  = 1'b0;
    byp_pinf = 1'b0;
    byp_ninf = 1'b0;
    if (IN_DATA[14:0] == 15'd0) begin
      byp_hit = 1'b1;
    end else if (IN_DATA[14:10] == 5'h1F) begin
      byp_hit = 1'b1;
      byp_dat = QNAN;
      if (IN_DATA[9:0] != 10'd0) begin
        byp_nan = 1'b1;
      end else if (IN_DATA[15]) begin
        byp_ninf = 1'b1;
      end else begin
        byp_dat  = PINF;
        byp_pinf = 1'b1;
      end
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    wcnt_d  = wcnt_q;
    gcnt_d  = gcnt_q;
    res_d   = res_q;
    nan_d   = nan_q;
    pinf_d  = pinf_q;
    ninf_d  = ninf_q;
    to_d    = to_q;
`ifdef SQRT2_BUS_CTRL_BYPASS_EN
    bypass_d = bypass_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d    = IN_DATA;
          wcnt_d  = '0;
          state_d = S_DRIVE;
`ifdef SQRT2_BUS_CTRL_BYPASS_EN
          bypass_d = byp_hit;
          if (byp_hit) begin
            state_d = S_HOLD;
            res_d   = byp_dat;
            nan_d   = byp_nan;
            pinf_d  = byp_pinf;
            ninf_d  = byp_ninf;
            to_d    = 1'b0;
          end
`endif
        end
      end
      S_DRIVE: state_d = S_WAIT;
      S_WAIT: begin
        // Completion wins over a timeout landing on the same edge.
        if (done) begin
          res_d   = SQ_RESULT  ? SQ_IO_DATA :
                    SQ_IS_NAN  ? QNAN       :
                    SQ_IS_PINF ? PINF       : QNAN;
          nan_d   = SQ_IS_NAN;
          pinf_d  = SQ_IS_PINF;
          ninf_d  = SQ_IS_NINF;
          to_d    = 1'b0;
          state_d = S_HOLD;
        end else if (wcnt_q == WCW'(TIMEOUT_CYC - 1)) begin
          res_d   = QNAN;
          nan_d   = 1'b0;
          pinf_d  = 1'b0;
          ninf_d  = 1'b0;
          to_d    = 1'b1;
          state_d = S_HOLD;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      S_HOLD: begin
        if (OUT_READY) begin
          gcnt_d  = '0;
          state_d = S_GAP;
`ifdef SQRT2_BUS_CTRL_BYPASS_EN
          if (bypass_q) state_d = S_IDLE;
`endif
        end
      end
      S_GAP: begin
        if (gcnt_q == GCW'(GAP_CYC - 1)) state_d = S_IDLE;
        else gcnt_d = gcnt_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      wcnt_q  <= '0;
      gcnt_q  <= '0;
      res_q   <= '0;
      nan_q   <= 1'b0;
      pinf_q  <= 1'b0;
      ninf_q  <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      wcnt_q  <= wcnt_d;
      gcnt_q  <= gcnt_d;
      res_q   <= res_d;
      nan_q   <= nan_d;
      pinf_q  <= pinf_d;
      ninf_q  <= ninf_d;
      to_q    <= to_d;
    end
  end

`ifdef SQRT2_BUS_CTRL_BYPASS_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) bypass_q <= 1'b0;
    else        bypass_q <= bypass_d;
  end
`endif
endmodule

// File: tb/tb_sqrt2_bus_ctrl.sv
// Scoreboard bench for sqrt2_bus_ctrl with a behavioural sqrt2 responder on the shared bus.
module tb_sqrt2_bus_ctrl;
  localparam int GAP_CYC = 1;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b1;
  logic        IN_VALID = 1'b0;
  logic [15:0] IN_DATA = 16'h0;
  logic        OUT_READY = 1'b1;
  logic        IN_READY, OUT_VALID, OUT_NAN, OUT_PINF, OUT_NINF, OUT_TIMEOUT, BUSY, SQ_ENABLE;
  logic [15:0] OUT_DATA;
  wire  [15:0] sq_bus;

  logic [3:0]  sq_st = 4'b0;
  logic        sq_drv_en = 1'b0;
  logic [15:0] sq_drv = 16'h0;
  assign sq_bus = sq_drv_en ? sq_drv : 16'hzzzz;

  // Nonzero operands only, so an undriven bus reading as zero still counts as free.
  wire       bus_free = (sq_bus === 16'hzzzz) || (sq_bus === 16'h0000);
  wire [3:0] out_fl   = {OUT_NAN, OUT_PINF, OUT_NINF, OUT_TIMEOUT};

  sqrt2_bus_ctrl #(.TIMEOUT_CYC(64), .GAP_CYC(GAP_CYC)) dut (
    .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_DATA(IN_DATA),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA), .OUT_NAN(OUT_NAN),
    .OUT_PINF(OUT_PINF), .OUT_NINF(OUT_NINF), .OUT_TIMEOUT(OUT_TIMEOUT), .BUSY(BUSY),
    .SQ_IO_DATA(sq_bus), .SQ_ENABLE(SQ_ENABLE), .SQ_IS_NAN(sq_st[2]), .SQ_IS_PINF(sq_st[1]),
    .SQ_IS_NINF(sq_st[0]), .SQ_RESULT(sq_st[3])
  );

  always #5 CLK = ~CLK;

  typedef struct { logic [15:0] dat; logic [3:0] fl; int lat; } exp_t;
  typedef struct { logic [15:0] op; int n; logic [3:0] mf; logic [15:0] mdat; logic [15:0] xdat; logic [3:0] xfl; } vec_t;
  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // sqrt2 responder: model_f = {RESULT, NAN, PINF, NINF}; model_n = 0 never answers.
  int          model_n = 0;
  logic [3:0]  model_f = 4'b0;
  logic [15:0] model_dat = 16'h0;
  logic [15:0] m_seen = 16'h0;
  int          m_cnt = 0;
  bit          m_active = 0;
  bit          en_prev = 0;

  initial forever begin
    @(posedge CLK);
    cyc = cyc + 1;
  end

  initial forever begin
    @(posedge CLK or negedge RST_N);
    if (!RST_N) begin
      m_active = 0; en_prev = 0; sq_st <= 4'b0; sq_drv_en <= 1'b0;
    end else begin
      if (sq_st != 4'b0) begin sq_st <= 4'b0; sq_drv_en <= 1'b0; end
      if (SQ_ENABLE && !en_prev) begin m_active = 1; m_cnt = 0; m_seen = sq_bus; end
      if (m_active) begin
        m_cnt++;
        if (m_cnt == model_n) begin
          sq_st <= model_f; sq_drv_en <= model_f[3]; sq_drv <= model_dat; m_active = 0;
        end
      end
      en_prev = SQ_ENABLE;
    end
  end

  task automatic send_op(input logic [15:0] d, output int acc, output bit ok);
    ok = 0;
    @(negedge CLK);
    IN_DATA = d; IN_VALID = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (IN_READY) ok = 1; else @(negedge CLK);
    end
    @(posedge CLK); #1;
    acc = cyc; IN_VALID = 1'b0;
  endtask

  task automatic wait_out(input int limit, output int obs, output bit got, output int dc, output logic [15:0] dv, output bit en);
    got = 0; dc = 0; dv = 16'h0; en = 0; obs = 0;
    for (int i = 0; i < limit && !got; i++) begin
      @(negedge CLK);
      if (SQ_ENABLE) en = 1;
      if (!sq_drv_en && !bus_free) begin dc++; dv = sq_bus; end
      if (OUT_VALID) begin got = 1; obs = cyc; end
    end
  endtask

  task automatic test_reset();
    #1 RST_N = 1'b0;
    @(negedge CLK); @(negedge CLK);
    checks++; if ({IN_READY, OUT_VALID, BUSY, SQ_ENABLE} !== 4'b0) begin failures++; $display("FAIL reset_ctrl got rdy/vld/busy/en=%b want 0000", {IN_READY, OUT_VALID, BUSY, SQ_ENABLE}); end
    checks++; if (OUT_DATA !== 16'h0 || out_fl !== 4'b0) begin failures++; $display("FAIL reset_out got data=%h flags=%b want 0000/0000", OUT_DATA, out_fl); end
    checks++; if (!bus_free) begin failures++; $display("FAIL reset_bus got %h want Z", sq_bus); end
    RST_N = 1'b1;
    @(negedge CLK);
    checks++; if (IN_READY !== 1'b1) begin failures++; $display("FAIL reset_idle_ready got %b want 1", IN_READY); end
  endtask

  task automatic test_normal();
    exp_t e; exp_t x; int acc, obs, dc; bit ok, got, en; logic [15:0] dv;
    model_n = 11; model_f = 4'b1000; model_dat = 16'h3C00;
    send_op(16'h3C00, acc, ok);
    e.dat = 16'h3C00; e.fl = 4'b0000; e.lat = 12; sb.push_back(e);
    wait_out(200, obs, got, dc, dv, en);
    x = sb.pop_front();
    checks++; if (!(ok && got)) begin failures++; $display("FAIL normal_handshake got ok=%0d out=%0d want 1/1", ok, got); end
    checks++; if (OUT_DATA !== x.dat) begin failures++; $display("FAIL normal_data got %h want %h", OUT_DATA, x.dat); end
    checks++; if (out_fl !== x.fl) begin failures++; $display("FAIL normal_flags got %b want %b", out_fl, x.fl); end
    checks++; if ((obs - acc) != x.lat) begin failures++; $display("FAIL normal_latency got %0d want %0d", obs - acc, x.lat); end
    checks++; if (dc != 1 || dv !== 16'h3C00) begin failures++; $display("FAIL normal_bus_drive got cycles=%0d val=%h want 1/3c00", dc, dv); end
    checks++; if (m_seen !== 16'h3C00) begin failures++; $display("FAIL normal_operand got %h want 3c00", m_seen); end
    @(posedge CLK); #1;
  endtask

  task automatic test_backpressure();
    exp_t e; exp_t x; int acc, obs, dc, gaps; bit ok, got, en; logic [15:0] dv;
    OUT_READY = 1'b0;
    model_n = 3; model_f = 4'b1000; model_dat = 16'h3DA8;
    send_op(16'h4000, acc, ok);
    e.dat = 16'h3DA8; e.fl = 4'b0000; e.lat = 4; sb.push_back(e);
    wait_out(200, obs, got, dc, dv, en);
    x = sb.pop_front();
    checks++; if (!(ok && got) || (obs - acc) != x.lat) begin failures++; $display("FAIL bp_latency got ok=%0d out=%0d lat=%0d want 1/1/%0d", ok, got, obs - acc, x.lat); end
    for (int i = 0; i < 5; i++) begin
      checks++; if ({OUT_VALID, OUT_DATA, out_fl, SQ_ENABLE, IN_READY} !== {1'b1, x.dat, x.fl, 1'b0, 1'b0}) begin failures++; $display("FAIL bp_hold_%0d got vld=%b data=%h fl=%b en=%b rdy=%b want 1/%h/%b/0/0", i, OUT_VALID, OUT_DATA, out_fl, SQ_ENABLE, IN_READY, x.dat, x.fl); end
      @(negedge CLK);
    end
    OUT_READY = 1'b1;
    gaps = 0;
    @(negedge CLK);
    checks++; if (OUT_VALID !== 1'b0 || SQ_ENABLE !== 1'b0) begin failures++; $display("FAIL bp_release got vld=%b en=%b want 0/0", OUT_VALID, SQ_ENABLE); end
    for (int i = 0; i < 20 && !IN_READY; i++) begin gaps++; @(negedge CLK); end
    checks++; if (gaps != GAP_CYC) begin failures++; $display("FAIL bp_gap got %0d idle-not-ready cycles want %0d", gaps, GAP_CYC); end
  endtask

  task automatic test_status();
    vec_t tbl [5];
    exp_t e; exp_t x; int acc, obs, dc; bit ok, got, en; logic [15:0] dv;
    tbl = '{'{16'h7E00, 2, 4'b0100, 16'h0000, 16'h7E00, 4'b1000},
            '{16'h4200, 4, 4'b0010, 16'h0000, 16'h7C00, 4'b0100},
            '{16'h4600, 5, 4'b0001, 16'h0000, 16'h7E00, 4'b0010},
            '{16'h4800, 3, 4'b1010, 16'h1234, 16'h1234, 4'b0100},
            '{16'h4A00, 2, 4'b0111, 16'h0000, 16'h7E00, 4'b1110}};
    for (int i = 0; i < 5; i++) begin
      model_n = tbl[i].n; model_f = tbl[i].mf; model_dat = tbl[i].mdat;
      send_op(tbl[i].op, acc, ok);
      e.dat = tbl[i].xdat; e.fl = tbl[i].xfl; e.lat = tbl[i].n + 1;
`ifdef SQRT2_BUS_CTRL_BYPASS_EN
      if (tbl[i].op == 16'h7E00) e.lat = 1;
`endif
      sb.push_back(e);
      wait_out(200, obs, got, dc, dv, en);
      x = sb.pop_front();
      checks++; if (!(ok && got) || (obs - acc) != x.lat) begin failures++; $display("FAIL status_%0d_latency got ok=%0d out=%0d lat=%0d want 1/1/%0d", i, ok, got, obs - acc, x.lat); end
      checks++; if (OUT_DATA !== x.dat) begin failures++; $display("FAIL status_%0d_data got %h want %h", i, OUT_DATA, x.dat); end
      checks++; if (out_fl !== x.fl) begin failures++; $display("FAIL status_%0d_flags got %b want %b", i, out_fl, x.fl); end
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_timeout();
    exp_t e; exp_t x; int acc, obs, dc; bit ok, got, en; logic [15:0] dv;
    model_n = 0; model_f = 4'b0;
    send_op(16'h4400, acc, ok);
    e.dat = 16'h7E00; e.fl = 4'b0001; e.lat = 65; sb.push_back(e);
    wait_out(200, obs, got, dc, dv, en);
    x = sb.pop_front();
    checks++; if (!(ok && got) || (obs - acc) != x.lat) begin failures++; $display("FAIL timeout_latency got ok=%0d out=%0d lat=%0d want 1/1/%0d", ok, got, obs - acc, x.lat); end
    checks++; if (OUT_DATA !== x.dat || out_fl !== x.fl) begin failures++; $display("FAIL timeout_result got data=%h fl=%b want %h/%b", OUT_DATA, out_fl, x.dat, x.fl); end
    @(posedge CLK); #1;
  endtask

  task automatic test_reset_mid();
    int acc, seen; bit ok;
    model_n = 20; model_f = 4'b1000; model_dat = 16'h1111;
    send_op(16'h4C00, acc, ok);
    for (int i = 0; i < 5; i++) @(negedge CLK);
    checks++; if (!ok || SQ_ENABLE !== 1'b1) begin failures++; $display("FAIL midrst_in_wait got ok=%0d en=%b want 1/1", ok, SQ_ENABLE); end
    RST_N = 1'b0; #1;
    checks++; if ({SQ_ENABLE, IN_READY, BUSY, OUT_VALID} !== 4'b0 || !bus_free) begin failures++; $display("FAIL midrst_async got en/rdy/busy/vld=%b bus=%h want 0000/Z", {SQ_ENABLE, IN_READY, BUSY, OUT_VALID}, sq_bus); end
    @(negedge CLK); @(negedge CLK);
    RST_N = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin @(negedge CLK); if (OUT_VALID) seen++; end
    checks++; if (seen != 0) begin failures++; $display("FAIL midrst_no_output got %0d valid cycles want 0", seen); end
    test_normal();
  endtask

  task automatic test_back_to_back();
    exp_t e; exp_t x; int acc1, acc2, obs, dc; bit ok, got, en; logic [15:0] dv;
    model_n = 1; model_f = 4'b1000; model_dat = 16'h2222;
    send_op(16'h5000, acc1, ok);
    e.dat = 16'h2222; e.fl = 4'b0; e.lat = 2; sb.push_back(e);
    wait_out(200, obs, got, dc, dv, en);
    x = sb.pop_front();
    checks++; if (!(ok && got) || OUT_DATA !== x.dat || (obs - acc1) != x.lat) begin failures++; $display("FAIL b2b_first got data=%h lat=%0d want %h/%0d", OUT_DATA, obs - acc1, x.dat, x.lat); end
    @(posedge CLK); #1;
    model_dat = 16'h3333;
    send_op(16'h5200, acc2, ok);
    e.dat = 16'h3333; e.fl = 4'b0; e.lat = 2; sb.push_back(e);
    wait_out(200, obs, got, dc, dv, en);
    x = sb.pop_front();
    checks++; if (!(ok && got) || OUT_DATA !== x.dat || (obs - acc2) != x.lat) begin failures++; $display("FAIL b2b_second got data=%h lat=%0d want %h/%0d", OUT_DATA, obs - acc2, x.dat, x.lat); end
    checks++; if ((acc2 - acc1) < (1 + 1 + 1 + GAP_CYC)) begin failures++; $display("FAIL b2b_spacing got %0d cycles want >= %0d", acc2 - acc1, 3 + GAP_CYC); end
    @(posedge CLK); #1;
  endtask

`ifdef SQRT2_BUS_CTRL_BYPASS_EN
  task automatic test_bypass();
    exp_t e; exp_t x; int acc, obs, dc; bit ok, got, en; logic [15:0] dv;
    model_n = 0; model_f = 4'b0;
    send_op(16'hFC00, acc, ok);
    e.dat = 16'h7E00; e.fl = 4'b0010; e.lat = 1; sb.push_back(e);
    wait_out(50, obs, got, dc, dv, en);
    x = sb.pop_front();
    checks++; if (!(ok && got) || (obs - acc) != x.lat || en) begin failures++; $display("FAIL bypass_timing got lat=%0d en_seen=%0d want %0d/0", obs - acc, en, x.lat); end
    checks++; if (OUT_DATA !== x.dat || out_fl !== x.fl) begin failures++; $display("FAIL bypass_result got %h/%b want %h/%b", OUT_DATA, out_fl, x.dat, x.fl); end
    @(posedge CLK); #1;
    @(negedge CLK);
    checks++; if (IN_READY !== 1'b1 || SQ_ENABLE !== 1'b0) begin failures++; $display("FAIL bypass_no_gap got rdy=%b en=%b want 1/0", IN_READY, SQ_ENABLE); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_normal();
    test_backpressure();
    test_status();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
`ifdef SQRT2_BUS_CTRL_BYPASS_EN
    test_bypass();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sqrt2_bus_ctrl.md
Name: sqrt2_bus_ctrl

Overview:
Host-side sequencer sitting directly upstream of the sqrt2 half-precision square-root unit. Accepts FP16 operands on a valid/ready stream and drives them onto sqrt2's shared inout data bus for exactly one cycle with ENABLE high. It then tri-states the bus, waits for completion or special-value flags, captures the result, and presents it on a valid/ready output stream. It also enforces the ENABLE-low reset gap between operations and a completion timeout.

Parameters:
TIMEOUT_CYC, 64, max WAIT cycles before forced abort (>=16)
GAP_CYC, 1, cycles SQ_ENABLE held low after an op before next accept (>=1)

Ports:
CLK  in  1  clock, all state on posedge
RST_N  in  1  asynchronous active-low reset
IN_VALID  in  1  operand valid
IN_READY  out  1  operand accepted when IN_VALID&IN_READY at posedge
IN_DATA  in  16  FP16 operand
OUT_VALID  out  1  result valid
OUT_READY  in  1  result consumed when OUT_VALID&OUT_READY at posedge
OUT_DATA  out  16  FP16 result
OUT_NAN  out  1  captured IS_NAN
OUT_PINF  out  1  captured IS_PINF
OUT_NINF  out  1  captured IS_NINF
OUT_TIMEOUT  out  1  op aborted by timeout
BUSY  out  1  high in any state except IDLE
SQ_IO_DATA  inout  16  shared data bus to sqrt2
SQ_ENABLE  out  1  sqrt2 ENABLE
SQ_IS_NAN, SQ_IS_PINF, SQ_IS_NINF, SQ_RESULT  in  1 each  sqrt2 status

Behaviour:
- Reset (async, RST_N=0): state IDLE; SQ_ENABLE=0; SQ_IO_DATA=Z immediately; IN_READY=0 while in reset; OUT_VALID=0; OUT_DATA=0; all OUT_* flags=0; counters=0. Reset mid-op abandons the op silently, with no output.
- IDLE: IN_READY=1, SQ_ENABLE=0, bus Z. On accept, latch IN_DATA -> DRIVE.
- DRIVE (exactly 1 cycle): SQ_ENABLE=1; SQ_IO_DATA driven with latched operand -> WAIT.
- WAIT: SQ_ENABLE=1; bus Z (controller never drives outside DRIVE); wait counter increments each cycle.
  - At a posedge with any of SQ_RESULT/SQ_IS_NAN/SQ_IS_PINF/SQ_IS_NINF high, capture the result -> HOLD.
  - If SQ_RESULT is high: OUT_DATA = sampled SQ_IO_DATA, and the flags are copied as sampled.
  - Else the flags are copied and OUT_DATA is canonical: NAN -> 16'h7E00; PINF -> 16'h7C00; NINF -> 16'h7E00.
  - If the counter reaches TIMEOUT_CYC with no completion: OUT_TIMEOUT=1, OUT_DATA=16'h7E00, other flags 0 -> HOLD.
- HOLD: OUT_VALID=1; SQ_ENABLE=0 (drops on entry); OUT_* stable until handshake. On OUT_READY -> GAP; OUT_VALID falls next cycle.
- GAP: SQ_ENABLE=0, IN_READY=0 for GAP_CYC cycles, then -> IDLE.
- Latency: accept at edge E0; DRIVE E0..E1; completion sampled at edge Ek; OUT_VALID high from Ek. With sqrt2 asserting RESULT n cycles after DRIVE, OUT_VALID rises 1+n cycles after accept.
- Simultaneous status bits: all captured together. SQ_RESULT data takes precedence over canonical values.
- IN_VALID while not IDLE: ignored (IN_READY=0); operand held by the source.
- Back-to-back throughput: one op per 1+n+1+GAP_CYC cycles minimum.

Optional Feature:
SQRT2_BUS_CTRL_BYPASS_EN.
- Defined: in IDLE, an accepted special operand skips sqrt2. SQ_ENABLE stays 0 and the state goes straight to HOLD next cycle (OUT_VALID one cycle after accept, GAP not entered afterwards).
  - +0 (0000) -> 0000
  - -0 (8000) -> 8000
  - +inf (7C00) -> 7C00 with OUT_PINF
  - -inf (FC00) -> 7E00 with OUT_NINF
  - any NaN (exp=1F, mant!=0) -> 7E00 with OUT_NAN
  - All other operands use the normal path.
- Undefined: every operand goes through DRIVE/WAIT.

Test Plan:
1. Send 3C00; sqrt2 model returns RESULT with bus 3C00 eleven cycles after DRIVE -> OUT_DATA=3C00, flags 0, OUT_VALID rises 12 cycles after accept, SQ_IO_DATA driven only during DRIVE.
2. Send 4000; model returns 3DA8; OUT_READY held low 5 cycles -> OUT_DATA stable at 3DA8, SQ_ENABLE=0 throughout HOLD, then GAP_CYC low cycles before IN_READY=1.
3. Send 7E00; model asserts only IS_NAN after 2 cycles -> OUT_DATA=7E00, OUT_NAN=1, others 0 (bypass macro undefined).
4. Send 4400; model never completes -> after TIMEOUT_CYC=64 WAIT cycles OUT_TIMEOUT=1, OUT_DATA=7E00.
5. Pull RST_N low during WAIT -> SQ_ENABLE=0 and bus Z asynchronously; no OUT_VALID after release; next op completes normally.
6. With SQRT2_BUS_CTRL_BYPASS_EN: send FC00 -> OUT_VALID next cycle, OUT_DATA=7E00, OUT_NINF=1, SQ_ENABLE never asserted.
